// File: rtl/conv_result_writer.sv
// Captures parallel conv result vectors, queues them and writes them to BRAM one word per cycle
// at channel-major addresses. Optional ReLU on the written data: define RESULT_WRITER_RELU_EN.
module conv_result_writer #(
    parameter int NUM_PE     = 4,
    parameter int OUT_FM_CH  = 2,
    parameter int DW         = 16,
    parameter int OUT_PIXELS = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 10
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_go,
    input  logic                             i_en,
    input  logic [DW*NUM_PE*OUT_FM_CH-1:0]   i_conv_result,
    output logic                             o_bram_we,
    output logic [ADDR_W-1:0]                o_bram_addr,
    output logic [DW-1:0]                    o_bram_data,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_ovf
);

    localparam int NW   = NUM_PE * OUT_FM_CH;
    localparam int VW   = DW * NW;
    localparam int PW   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int CW   = (OUT_FM_CH > 1) ? $clog2(OUT_FM_CH) : 1;
    localparam int WW   = (NW > 1) ? $clog2(NW) : 1;
    localparam int FW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    localparam logic [PW-1:0]     P_LAST    = PW'(NUM_PE - 1);
    localparam logic [WW-1:0]     W_LAST    = WW'(NW - 1);
    localparam logic [ADDR_W-1:0] PIX_STEP  = ADDR_W'(NUM_PE);
    localparam logic [ADDR_W-1:0] PIX_END   = ADDR_W'(OUT_PIXELS);
    localparam logic [ADDR_W-1:0] CH_STRIDE = ADDR_W'(OUT_PIXELS);
    localparam logic [CNTW-1:0]   CNT_FULL  = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;
    logic   run;

    logic [VW-1:0]     mem [FIFO_DEPTH];
    logic [FW-1:0]     wr_ptr, rd_ptr;
    logic [CNTW-1:0]   count;
    logic              cur_vld;
    logic [VW-1:0]     cur_vec;
    logic [WW-1:0]     widx;
    logic [PW-1:0]     p_cnt;
    logic [CW-1:0]     ch_cnt;
    logic [ADDR_W-1:0] pix_base;
    logic              ovf_q, done_q;

    // i_go restarts the pass in the same cycle, so counters are viewed through it
    logic              cv_e;
    logic [CNTW-1:0]   cnt_e;
    logic [FW-1:0]     wp_e, rp_e;
    logic [WW-1:0]     widx_e;
    logic [PW-1:0]     p_e;
    logic [CW-1:0]     ch_e;
    logic [ADDR_W-1:0] pb_e;
    logic [VW-1:0]     src;
    logic [DW-1:0]     src_words [NW];
    logic [DW-1:0]     word;
    logic [ADDR_W-1:0] addr;
    logic              issue, last_w, last, fin, fifo_pop, in_cur, in_next, push, drop;

    function automatic logic [DW-1:0] relu(input logic signed [DW-1:0] w);
`ifdef RESULT_WRITER_RELU_EN
        return (w < 0) ? '0 : w;
`else
        return w;
`endif
    endfunction

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (i_go) state_next = RUN;
        if (fin)  state_next = DONE;
    end

    always_comb begin
        run = (state == RUN) | i_go;
    end

    always_comb begin
        cv_e   = cur_vld & ~i_go;
        cnt_e  = i_go ? '0 : count;
        wp_e   = i_go ? '0 : wr_ptr;
        rp_e   = i_go ? '0 : rd_ptr;
        widx_e = i_go ? '0 : widx;
        p_e    = i_go ? '0 : p_cnt;
        ch_e   = i_go ? '0 : ch_cnt;
        pb_e   = i_go ? '0 : pix_base;

        // An idle writer takes the incoming vector straight to the output register
        src = cv_e ? cur_vec : i_conv_result;
        for (int i = 0; i < NW; i++) src_words[i] = src[i*DW +: DW];
        word = src_words[widx_e];
        addr = CH_STRIDE * ADDR_W'(ch_e) + pb_e + ADDR_W'(p_e);

        issue    = run & (cv_e | i_en);
        last_w   = (widx_e == W_LAST);
        last     = issue & last_w;
        fin      = last & ((pb_e + PIX_STEP) == PIX_END);
        fifo_pop = last & (cnt_e != '0);
        in_cur   = run & i_en & ~cv_e;
        in_next  = run & i_en & cv_e & last & (cnt_e == '0);
        push     = run & i_en & cv_e & ~in_next & ((cnt_e != CNT_FULL) | fifo_pop);
        drop     = i_en & ~(in_cur | in_next | push);
    end

    // Output register stage and control state
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_bram_we   <= 1'b0;
            o_bram_addr <= '0;
            o_bram_data <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cur_vld     <= 1'b0;
            widx        <= '0;
            p_cnt       <= '0;
            ch_cnt      <= '0;
            pix_base    <= '0;
        end else begin
            o_bram_we <= issue;
            if (issue) begin
                o_bram_addr <= addr;
                o_bram_data <= relu(word);
            end
            ovf_q  <= (ovf_q & ~i_go) | drop;
            done_q <= (state == DONE) & ~i_go;
            if (fin) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                cur_vld  <= 1'b0;
                widx     <= '0;
                p_cnt    <= '0;
                ch_cnt   <= '0;
                pix_base <= pb_e + PIX_STEP;
            end else begin
                wr_ptr <= wp_e + FW'(push);
                rd_ptr <= rp_e + FW'(fifo_pop);
                count  <= cnt_e + CNTW'(push) - CNTW'(fifo_pop);
                if (issue && last_w) begin
                    widx     <= '0;
                    p_cnt    <= '0;
                    ch_cnt   <= '0;
                    pix_base <= pb_e + PIX_STEP;
                    cur_vld  <= fifo_pop | in_next;
                end else if (issue) begin
                    widx     <= widx_e + WW'(1);
                    pix_base <= pb_e;
                    cur_vld  <= 1'b1;
                    if (p_e == P_LAST) begin
                        p_cnt  <= '0;
                        ch_cnt <= ch_e + CW'(1);
                    end else begin
                        p_cnt  <= p_e + PW'(1);
                        ch_cnt <= ch_e;
                    end
                end else begin
                    widx     <= widx_e;
                    p_cnt    <= p_e;
                    ch_cnt   <= ch_e;
                    pix_base <= pb_e;
                    cur_vld  <= cv_e;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wp_e] <= i_conv_result;
        if (fifo_pop)              cur_vec <= mem[rp_e];
        else if (in_cur | in_next) cur_vec <= i_conv_result;
    end

    assign o_busy = (count != '0) | o_bram_we;
    assign o_done = done_q;
    assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_conv_result_writer.sv
// Randomised bench for conv_result_writer against a queue-based reference model of the pass.
module tb_conv_result_writer;

    localparam int NUM_PE     = 4;
    localparam int OUT_FM_CH  = 2;
    localparam int DW         = 16;
    localparam int OUT_PIXELS = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 10;
    localparam int NW         = NUM_PE * OUT_FM_CH;
    localparam int VW         = DW * NW;

    logic              clk;
    logic              i_rst;
    logic              i_go;
    logic              i_en;
    logic [VW-1:0]     i_conv_result;
    logic              o_bram_we;
    logic [ADDR_W-1:0] o_bram_addr;
    logic [DW-1:0]     o_bram_data;
    logic              o_busy;
    logic              o_done;
    logic              o_ovf;

    conv_result_writer #(
        .NUM_PE(NUM_PE), .OUT_FM_CH(OUT_FM_CH), .DW(DW),
        .OUT_PIXELS(OUT_PIXELS), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_go(i_go), .i_en(i_en),
        .i_conv_result(i_conv_result),
        .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr), .o_bram_data(o_bram_data),
        .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: accepted vectors in arrival order, head being written word by word
    logic [VW-1:0]     mq[$];
    int                m_widx, m_pix;
    bit                m_active, m_done_state;
    bit                m_we, m_busy, m_done, m_ovf;
    logic [ADDR_W-1:0] m_addr;
    logic [DW-1:0]     m_data;

    function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] w);
`ifdef RESULT_WRITER_RELU_EN
        if ($signed(w) < 0) return '0;
`endif
        return w;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_widx = 0; m_pix = 0;
        m_active = 0; m_done_state = 0;
        m_we = 0; m_busy = 0; m_done = 0; m_ovf = 0;
        m_addr = '0; m_data = '0;
    endtask

    task automatic model_step(input bit go, input bit en, input logic [VW-1:0] vec);
        int ch, p;
        logic [VW-1:0] head;
        m_done = m_done_state && !go;
        if (go) begin
            mq.delete();
            m_widx = 0; m_pix = 0; m_ovf = 0;
            m_active = 1; m_done_state = 0;
        end
        // FIFO_DEPTH waiting vectors plus the one being written; a finishing head frees a slot
        if (en) begin
            if (m_active && (mq.size() <= FIFO_DEPTH || m_widx == NW - 1)) mq.push_back(vec);
            else m_ovf = 1;
        end
        m_we = 0;
        if (m_active && mq.size() > 0) begin
            head   = mq[0];
            ch     = m_widx / NUM_PE;
            p      = m_widx % NUM_PE;
            m_we   = 1;
            m_addr = ADDR_W'(ch * OUT_PIXELS + m_pix + p);
            m_data = relu_ref(head[(ch*NUM_PE + p)*DW +: DW]);
            m_widx++;
            if (m_widx == NW) begin
                void'(mq.pop_front());
                m_widx = 0;
                m_pix += NUM_PE;
                if (m_pix == OUT_PIXELS) begin
                    m_active = 0;
                    m_done_state = 1;
                    mq.delete();
                end
            end
        end
        m_busy = (mq.size() > 1) || m_we;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_we"},   64'(o_bram_we),   64'(m_we));
        check({tag, "_addr"}, 64'(o_bram_addr), 64'(m_addr));
        check({tag, "_data"}, 64'(o_bram_data), 64'(m_data));
        check({tag, "_busy"}, 64'(o_busy),      64'(m_busy));
        check({tag, "_done"}, 64'(o_done),      64'(m_done));
        check({tag, "_ovf"},  64'(o_ovf),       64'(m_ovf));
    endtask

    task automatic cyc(input string tag, input bit go, input bit en, input logic [VW-1:0] vec);
        i_go = go; i_en = en; i_conv_result = vec;
        model_step(go, en, vec);
        @(posedge clk); #1;
        check_all(tag);
        i_go = 1'b0; i_en = 1'b0;
    endtask

    function automatic logic [VW-1:0] pat_vec(input int base);
        logic [VW-1:0] v;
        v = '0;
        for (int ch = 0; ch < OUT_FM_CH; ch++)
            for (int p = 0; p < NUM_PE; p++)
                v[(ch*NUM_PE + p)*DW +: DW] = DW'(base + ch*16 + p);
        return v;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 0, 0, '0);
    endtask

    initial begin
        logic [VW-1:0] v;
        i_rst = 1'b0; i_go = 1'b0; i_en = 1'b0; i_conv_result = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        i_rst = 1'b1;
        idle("idle", 3);

        // single vector: words ch*16+p
        cyc("single", 1, 0, '0);
        cyc("single", 0, 1, pat_vec(0));
        idle("single", 10);

        // full pass from two vectors one cycle apart
        cyc("pass", 1, 0, '0);
        cyc("pass", 0, 1, pat_vec(32));
        cyc("pass", 0, 1, pat_vec(64));
        idle("pass", 20);

        // overflow: six back-to-back vectors
        cyc("ovf", 1, 0, '0);
        for (int i = 0; i < 6; i++) cyc("ovf", 0, 1, rnd_vec());
        idle("ovf", 20);
        cyc("ovf_late", 0, 1, rnd_vec());
        idle("ovf_late", 2);

        // negative word at (0,0)
        v = pat_vec(100);
        v[DW-1:0] = 16'hFFF6;
        v[DW +: DW] = 16'h8000;
        cyc("relu", 1, 0, '0);
        cyc("relu", 0, 1, v);
        idle("relu", 10);

        // restart during a drain, with a vector captured on the go cycle
        cyc("regos", 1, 0, '0);
        cyc("regos", 0, 1, rnd_vec());
        cyc("regos", 0, 1, rnd_vec());
        idle("regos", 3);
        cyc("regos", 1, 1, pat_vec(200));
        idle("regos", 12);

        // reset while draining
        cyc("rstmid", 1, 1, rnd_vec());
        cyc("rstmid", 0, 1, rnd_vec());
        idle("rstmid", 2);
        i_rst = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk); #1;
        check_all("rst_hold");
        i_rst = 1'b1;
        idle("rst_after", 6);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit go, en;
            go = (i == 0) || ($urandom_range(0, 39) == 0);
            en = ($urandom_range(0, 9) < 4);
            cyc("rand", go, en, rnd_vec());
        end
        idle("rand_tail", 40);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
